// File: rtl/ecc_pkg.sv
// Shared SECDED codeword layout helpers used by the encoder and decoder.
package ecc_pkg;

    typedef struct packed {
        logic sbe;
        logic dbe;
    } ecc_status_t;

    // Returns 1 if pos is a power of two; those positions hold Hamming bits.
    function automatic logic ecc_is_pow2(input int unsigned pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Returns the smallest k with 2^k >= data_w + k + 1.
    function automatic int unsigned ecc_ham_w(input int unsigned data_w);
        int unsigned k;
        k = 1;
        while ((32'd1 << k) < (data_w + k + 1)) k++;
        return k;
    endfunction

    // Returns the Hamming position of data bit idx (data bit 0 sits at position 3).
    function automatic int unsigned ecc_data_pos(input int unsigned idx);
        int unsigned pos;
        int unsigned cnt;
        pos = 2;
        cnt = 0;
        while (cnt <= idx) begin
            pos++;
            if (!ecc_is_pow2(pos)) cnt++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_decoder_if.sv
// Read-data bus between the SRAM read port and the SECDED decoder.
interface ecc_secded_decoder_if
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned HAM_W  = ecc_ham_w(DATA_W);
    localparam int unsigned CODE_W = HAM_W + 1;

    logic [DATA_W-1:0] i_data;
    logic [CODE_W-1:0] i_code;
    logic              i_vld;
    logic              i_clr_cnt;
    logic [DATA_W-1:0] o_data;
    logic              o_vld;
    logic              o_sbe;
    logic              o_dbe;
    logic [HAM_W-1:0]  o_syndrome;
    logic [CNT_W-1:0]  o_sbe_cnt;
    logic [CNT_W-1:0]  o_dbe_cnt;
    logic [HAM_W-1:0]  o_last_syn;

    modport master (
        output i_data, i_code, i_vld, i_clr_cnt,
        input  o_data, o_vld, o_sbe, o_dbe, o_syndrome, o_sbe_cnt, o_dbe_cnt, o_last_syn
    );

    modport slave (
        input  i_data, i_code, i_vld, i_clr_cnt,
        output o_data, o_vld, o_sbe, o_dbe, o_syndrome, o_sbe_cnt, o_dbe_cnt, o_last_syn
    );

endinterface

// File: rtl/ecc_err_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module ecc_err_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/ecc_secded_decoder.sv
// Two-stage SECDED decoder for SRAM read data.
// Define ECC_ERR_CNT_EN to build the error counters and last-syndrome register.
module ecc_secded_decoder
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ecc_secded_decoder_if.slave  bus
);

    localparam int unsigned HAM_W  = ecc_ham_w(DATA_W);
    localparam int unsigned CODE_W = HAM_W + 1;
    localparam int unsigned N      = DATA_W + HAM_W;

    // Data bits that contribute to syndrome bit j.
    function automatic logic [DATA_W-1:0] syn_mask(input int unsigned j);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            m[i] = ((ecc_data_pos(i) >> j) & 32'd1) != 32'd0;
        end
        return m;
    endfunction

    logic [HAM_W-1:0]  syn_c;
    logic [DATA_W-1:0] flip_c;

    logic              s1_vld_d,  s1_vld_q;
    logic [HAM_W-1:0]  s1_syn_d,  s1_syn_q;
    logic              s1_par_d,  s1_par_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;

    logic              out_vld_d,  out_vld_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    ecc_status_t       out_st_d,   out_st_q;
    logic [HAM_W-1:0]  out_syn_d,  out_syn_q;

    for (genvar j = 0; j < HAM_W; j++) begin : g_syn
        localparam logic [DATA_W-1:0] MASK = syn_mask(j);
        assign syn_c[j] = (^(bus.i_data & MASK)) ^ bus.i_code[j];
    end

    // One-hot correction mask: only the data bit whose position matches the syndrome.
    for (genvar i = 0; i < DATA_W; i++) begin : g_fix
        localparam int unsigned POS = ecc_data_pos(i);
        assign flip_c[i] = (s1_syn_q == HAM_W'(POS));
    end

    always_comb begin
        s1_vld_d  = bus.i_vld;
        s1_syn_d  = syn_c;
        s1_par_d  = ^{bus.i_data, bus.i_code};
        s1_data_d = bus.i_data;
    end

    always_comb begin
        out_vld_d  = s1_vld_q;
        out_data_d = s1_data_q;
        out_st_d   = '0;
        out_syn_d  = '0;
        if (s1_vld_q) begin
            out_syn_d = s1_syn_q;
            if (s1_syn_q == '0) begin
                out_st_d.sbe = s1_par_q;
            end else if (!s1_par_q) begin
                out_st_d.dbe = 1'b1;
            end else if (32'(s1_syn_q) > N) begin
                out_st_d.dbe = 1'b1;
            end else begin
                out_st_d.sbe = 1'b1;
                out_data_d   = s1_data_q ^ flip_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q   <= 1'b0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s1_data_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_st_q   <= '0;
            out_syn_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
            s1_data_q  <= s1_data_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_st_q   <= out_st_d;
            out_syn_q  <= out_syn_d;
        end
    end

    assign bus.o_vld      = out_vld_q;
    assign bus.o_data     = out_data_q;
    assign bus.o_sbe      = out_st_q.sbe;
    assign bus.o_dbe      = out_st_q.dbe;
    assign bus.o_syndrome = out_syn_q;

`ifdef ECC_ERR_CNT_EN
    logic             sbe_inc_c;
    logic             dbe_inc_c;
    logic [CNT_W-1:0] sbe_cnt;
    logic [CNT_W-1:0] dbe_cnt;
    logic [HAM_W-1:0] last_syn_d, last_syn_q;

    assign sbe_inc_c = out_vld_q & out_st_q.sbe;
    assign dbe_inc_c = out_vld_q & out_st_q.dbe;

    ecc_err_counter #(.CNT_W(CNT_W)) u_sbe_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (bus.i_clr_cnt),
        .i_inc (sbe_inc_c),
        .o_cnt (sbe_cnt)
    );

    ecc_err_counter #(.CNT_W(CNT_W)) u_dbe_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (bus.i_clr_cnt),
        .i_inc (dbe_inc_c),
        .o_cnt (dbe_cnt)
    );

    always_comb begin
        last_syn_d = last_syn_q;
        if (bus.i_clr_cnt) begin
            last_syn_d = '0;
        end else if (sbe_inc_c || dbe_inc_c) begin
            last_syn_d = out_syn_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) last_syn_q <= '0;
        else       last_syn_q <= last_syn_d;
    end

    assign bus.o_sbe_cnt  = sbe_cnt;
    assign bus.o_dbe_cnt  = dbe_cnt;
    assign bus.o_last_syn = last_syn_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = bus.i_clr_cnt;

    assign bus.o_sbe_cnt  = '0;
    assign bus.o_dbe_cnt  = '0;
    assign bus.o_last_syn = '0;
`endif

    logic [CODE_W-1:0] unused_code_w;
    assign unused_code_w = bus.i_code;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Scoreboard bench for ecc_secded_decoder: a 26-bit/16-bit-counter instance and an 8-bit/2-bit-counter instance.
module tb_ecc_secded_decoder;

`ifdef ECC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        sbe;
        logic        dbe;
        logic [7:0]  syn;
    } exp_t;

    typedef struct {
        string       name;
        int          id;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst26;
    logic rst8;

    always #5 clk = ~clk;

    ecc_secded_decoder_if #(.DATA_W(26), .CNT_W(16)) bus26 ();
    ecc_secded_decoder_if #(.DATA_W(8),  .CNT_W(2))  bus8  ();

    ecc_secded_decoder #(.DATA_W(26), .CNT_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst26),
        .bus   (bus26.slave)
    );

    ecc_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut8 (
        .i_clk (clk),
        .i_rst (rst8),
        .bus   (bus8.slave)
    );

    exp_t q26[$];
    exp_t q8[$];
    chk_t cq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference encoder: returns Hamming bits in [hw-1:0] and overall parity at [hw].
    function automatic logic [31:0] enc(input logic [31:0] d, input int dw, input int hw);
        logic [31:0] s;
        logic [31:0] code;
        logic        par;
        int          di;
        s  = '0;
        di = 0;
        for (int pos = 1; pos < 64; pos++) begin
            if (((pos & (pos - 1)) != 0) && (di < dw)) begin
                if (d[di]) s = s ^ 32'(pos);
                di++;
            end
        end
        code = s & ((32'd1 << hw) - 32'd1);
        par  = (^(d & ((32'd1 << dw) - 32'd1))) ^ (^code);
        code[hw] = par;
        return code;
    endfunction

    function automatic logic [31:0] ecnt(input logic [31:0] v);
        return CNT_EN ? v : 32'd0;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic sbe, input logic dbe, input logic [7:0] syn);
        exp_t e;
        e.data = d;
        e.sbe  = sbe;
        e.dbe  = dbe;
        e.syn  = syn;
        return e;
    endfunction

    function automatic logic [31:0] get_act(input int id);
        case (id)
            0:       return 32'(bus26.o_sbe_cnt);
            1:       return 32'(bus26.o_dbe_cnt);
            2:       return 32'(bus26.o_last_syn);
            3:       return 32'(bus8.o_sbe_cnt);
            4:       return 32'(bus8.o_dbe_cnt);
            5:       return 32'(bus8.o_last_syn);
            6:       return 32'(q26.size() + q8.size());
            7:       return 32'(bus26.o_vld);
            8:       return 32'(bus26.o_data);
            default: return 32'(bus8.o_vld);
        endcase
    endfunction

    task automatic expect_chk(input string name, input int id, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.id   = id;
        c.exp  = v;
        cq.push_back(c);
    endtask

    // Monitor-side compare of one DUT output cycle against its scoreboard queue.
    task automatic mon_out(input string name, input int which, input logic vld, input logic [31:0] d,
                           input logic sbe, input logic dbe, input logic [7:0] syn);
        exp_t e;
        checks++;
        if (vld === 1'b1) begin
            if ((which == 0 && q26.size() == 0) || (which == 1 && q8.size() == 0)) begin
                errors++;
                $display("FAIL %s unexpected output: data=%h sbe=%b dbe=%b syn=%0d, no word expected", name, d, sbe, dbe, syn);
            end else begin
                e = (which == 0) ? q26.pop_front() : q8.pop_front();
                if (d !== e.data || sbe !== e.sbe || dbe !== e.dbe || syn !== e.syn) begin
                    errors++;
                    $display("FAIL %s word: got data=%h sbe=%b dbe=%b syn=%0d, want data=%h sbe=%b dbe=%b syn=%0d",
                             name, d, sbe, dbe, syn, e.data, e.sbe, e.dbe, e.syn);
                end
            end
        end else if (vld !== 1'b0 || sbe !== 1'b0 || dbe !== 1'b0 || syn !== 8'd0) begin
            errors++;
            $display("FAIL %s idle flags: got vld=%b sbe=%b dbe=%b syn=%0d, want all 0", name, vld, sbe, dbe, syn);
        end
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        mon_out("out26", 0, bus26.o_vld, 32'(bus26.o_data), bus26.o_sbe, bus26.o_dbe, 8'(bus26.o_syndrome));
        mon_out("out8",  1, bus8.o_vld,  32'(bus8.o_data),  bus8.o_sbe,  bus8.o_dbe,  8'(bus8.o_syndrome));
        while (cq.size() > 0) begin
            c   = cq.pop_front();
            act = get_act(c.id);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0d, want %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send26(input logic [25:0] d, input logic [5:0] c, input exp_t e);
        bus26.i_data = d;
        bus26.i_code = c;
        bus26.i_vld  = 1'b1;
        q26.push_back(e);
        step(1);
        bus26.i_vld  = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic [4:0] c, input exp_t e);
        bus8.i_data = d;
        bus8.i_code = c;
        bus8.i_vld  = 1'b1;
        q8.push_back(e);
        step(1);
        bus8.i_vld  = 1'b0;
    endtask

    initial begin
        rst26 = 1'b1;
        rst8  = 1'b1;
        bus26.i_data = '0; bus26.i_code = '0; bus26.i_vld = 1'b0; bus26.i_clr_cnt = 1'b0;
        bus8.i_data  = '0; bus8.i_code  = '0; bus8.i_vld  = 1'b0; bus8.i_clr_cnt  = 1'b0;
        step(3);
        expect_chk("reset o_vld26",   7, 32'd0);
        expect_chk("reset o_data26",  8, 32'd0);
        expect_chk("reset sbe_cnt26", 0, 32'd0);
        expect_chk("reset dbe_cnt26", 1, 32'd0);
        expect_chk("reset last26",    2, 32'd0);
        expect_chk("reset o_vld8",    9, 32'd0);
        step(1);
        rst26 = 1'b0;
        rst8  = 1'b0;
        step(1);

        // Clean back-to-back stream.
        for (int i = 0; i < 1000; i++) begin
            send26(26'(i), 6'(enc(32'(i), 26, 5)), mk(32'(i), 1'b0, 1'b0, 8'd0));
        end
        step(4);
        expect_chk("clean sbe_cnt26", 0, 32'd0);
        expect_chk("clean dbe_cnt26", 1, 32'd0);

        // 0x5 encodes to code 0x05; flipping data bit 0 gives data 0x4.
        send26(26'h0000004, 6'h05, mk(32'h5, 1'b1, 1'b0, 8'd3));
        step(4);
        expect_chk("sbe data bit0 cnt",  0, ecnt(32'd1));
        expect_chk("sbe data bit0 last", 2, ecnt(32'd3));

        send26(26'h0000005, 6'h04, mk(32'h5, 1'b1, 1'b0, 8'd1));
        send26(26'h0000005, 6'h25, mk(32'h5, 1'b1, 1'b0, 8'd0));
        step(4);
        expect_chk("sbe code flips cnt", 0, ecnt(32'd3));
        expect_chk("sbe overall last",   2, 32'd0);

        // Data bits 0 and 1 flipped: 0x5 -> 0x6, syndrome 3^5 = 6, even parity.
        send26(26'h0000006, 6'h05, mk(32'h6, 1'b0, 1'b1, 8'd6));
        step(4);
        expect_chk("dbe cnt26",  1, ecnt(32'd1));
        expect_chk("dbe last26", 2, ecnt(32'd6));
        expect_chk("dbe sbe26",  0, ecnt(32'd3));

        // Reset with two errored words in flight: neither may emerge.
        bus26.i_data = 26'h0000004;
        bus26.i_code = 6'h05;
        bus26.i_vld  = 1'b1;
        step(1);
        bus26.i_data = 26'h0000006;
        rst26 = 1'b1;
        step(1);
        rst26 = 1'b0;
        bus26.i_vld = 1'b0;
        expect_chk("rst flush o_vld26", 7, 32'd0);
        step(4);
        expect_chk("rst flush sbe26",  0, 32'd0);
        expect_chk("rst flush dbe26",  1, 32'd0);
        expect_chk("rst flush last26", 2, 32'd0);
        send26(26'h2AAAAAA, 6'(enc(32'h2AAAAAA, 26, 5)), mk(32'h2AAAAAA, 1'b0, 1'b0, 8'd0));

        // DATA_W=8: clean word, then syndrome 13 (>N=12) with odd parity.
        send8(8'hA5, 5'(enc(32'hA5, 8, 4)), mk(32'hA5, 1'b0, 1'b0, 8'd0));
        send8(8'h00, 5'b01101, mk(32'h0, 1'b0, 1'b1, 8'd13));
        step(4);
        expect_chk("syn13 dbe_cnt8", 4, ecnt(32'd1));
        expect_chk("syn13 last8",    5, ecnt(32'd13));

        for (int i = 0; i < 5; i++) send8(8'h00, 5'b00001, mk(32'h0, 1'b1, 1'b0, 8'd1));
        step(4);
        expect_chk("sat sbe_cnt8", 3, ecnt(32'd3));

        bus8.i_clr_cnt = 1'b1;
        step(1);
        bus8.i_clr_cnt = 1'b0;
        step(1);
        expect_chk("clr sbe_cnt8", 3, 32'd0);
        expect_chk("clr dbe_cnt8", 4, 32'd0);
        expect_chk("clr last8",    5, 32'd0);

        // Clear asserted in the very cycle the SBE word is on the output.
        send8(8'h00, 5'b00001, mk(32'h0, 1'b1, 1'b0, 8'd1));
        step(1);
        bus8.i_clr_cnt = 1'b1;
        step(1);
        bus8.i_clr_cnt = 1'b0;
        step(1);
        expect_chk("clr wins sbe_cnt8", 3, 32'd0);
        expect_chk("clr wins last8",    5, 32'd0);

        send8(8'h00, 5'b00001, mk(32'h0, 1'b1, 1'b0, 8'd1));
        step(4);
        expect_chk("post clr sbe_cnt8", 3, ecnt(32'd1));
        expect_chk("post clr last8",    5, ecnt(32'd1));

        step(2);
        expect_chk("scoreboard drained", 6, 32'd0);
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
